// File: rtl/rob.sv
// rob -- reorder buffer for the out-of-order core.
//
// Instructions arrive in program order from issue, results are captured from
// the common data bus (CDB), and completed entries retire in order, one per
// cycle, through a registered commit port that drives the register file.
//
// Optional feature macro: ROB_FLUSH_EN (adds the `flush` input for branch
// mispredict / exception recovery). Default build has no flush port.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              global ready; low freezes all state (commit_valid -> 0)
//   issue_valid/rd      instruction from issue stage
//   issue_tag           tag the instruction will get (current tail, comb.)
//   full, empty         registered occupancy flags
//   cdb_valid/tag/value result broadcast
//   commit_valid/rd/value/tag  registered retirement port
//   flush               (ROB_FLUSH_EN only) discard all in-flight entries
module rob #(
    parameter int ROB_SIZE = 16,
    parameter int TAG_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic [TAG_W-1:0] issue_tag,
    output logic             full,
    output logic             empty,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [TAG_W-1:0] commit_tag
`ifdef ROB_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [4:0]          rd_mem    [ROB_SIZE];
    logic [31:0]         value_mem [ROB_SIZE];

    logic [TAG_W-1:0]    head;
    logic [TAG_W-1:0]    tail;
    logic [TAG_W:0]      count;
    logic [TAG_W:0]      count_nxt;

    logic                flush_hit;
    logic                accept;
    logic                retire;
    logic                cdb_hit;

`ifdef ROB_FLUSH_EN
    assign flush_hit = rdy_in && flush;
`else
    assign flush_hit = 1'b0;
`endif

    // Flush outranks every other action in the same cycle.
    assign accept  = rdy_in && !flush_hit && issue_valid && !full;
    assign retire  = rdy_in && !flush_hit && busy[head] && ready[head];
    assign cdb_hit = rdy_in && !flush_hit && cdb_valid && busy[cdb_tag];

    assign issue_tag = tail;

    assign count_nxt = count + (TAG_W+1)'(accept) - (TAG_W+1)'(retire);

    // Pointers, occupancy and flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (flush_hit) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else if (rdy_in) begin
            if (accept) tail <= tail + 1'b1;
            if (retire) head <= head + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (TAG_W+1)'(ROB_SIZE));
            empty <= (count_nxt == '0);
        end
    end

    // Entry status bits. The retire clear is written after the CDB set so a
    // late CDB hit on the retiring head cannot leave a stale ready behind.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_hit) begin
            busy  <= '0;
            ready <= '0;
        end else if (rdy_in) begin
            if (cdb_hit) ready[cdb_tag] <= 1'b1;
            if (retire) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
            end
            if (accept) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: it is only read once busy/ready say so.
    always_ff @(posedge clk_in) begin
        if (accept)  rd_mem[tail]       <= issue_rd;
        if (cdb_hit) value_mem[cdb_tag] <= cdb_value;
    end

    // Commit port. Payload holds between retirements; the valid strobe is a
    // single-cycle pulse and is suppressed for x0 destinations.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
        end else if (!rdy_in || flush_hit) begin
            commit_valid <= 1'b0;
        end else if (retire) begin
            commit_valid <= (rd_mem[head] != 5'd0);
            commit_rd    <= rd_mem[head];
            commit_value <= value_mem[head];
            commit_tag   <= head;
        end else begin
            commit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios followed by randomized traffic, all
// checked against an in-order queue model of the reorder buffer.
module tb_rob;
    localparam int N = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, issue_valid, cdb_valid;
    logic [4:0]  issue_rd, commit_rd;
    logic [3:0]  issue_tag, cdb_tag, commit_tag;
    logic [31:0] cdb_value, commit_value;
    logic        full, empty, commit_valid;
`ifdef ROB_FLUSH_EN
    logic        flush;
`endif

    always #5 clk_in = ~clk_in;

    rob #(.ROB_SIZE(N), .TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .full(full), .empty(empty),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_tag(commit_tag)
`ifdef ROB_FLUSH_EN
        , .flush(flush)
`endif
    );

    // Model: in-flight instructions in program order.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] val;
    } ent_t;

    ent_t        q[$];
    int          m_tail;
    logic        m_cv;
    logic [4:0]  m_crd;
    logic [31:0] m_cval;
    logic [3:0]  m_ctag;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit rdy, input bit iv, input logic [4:0] ird,
                         input bit cv, input logic [3:0] ct, input logic [31:0] cval, input bit fl);
        bit   ret, acc;
        ent_t h;
        if (rst) begin
            q.delete(); m_tail = 0;
            m_cv = 0; m_crd = 0; m_cval = 0; m_ctag = 0;
        end else if (!rdy) begin
            m_cv = 0;
        end else if (fl) begin
            q.delete(); m_tail = 0; m_cv = 0;
        end else begin
            // Oldest instruction retires only if it was already complete.
            ret = (q.size() > 0) && q[0].done;
            if (ret) h = q[0];
            acc = iv && (q.size() < N);
            if (cv)
                foreach (q[i]) if (q[i].tag == int'(ct)) begin q[i].done = 1; q[i].val = cval; end
            if (ret) begin
                void'(q.pop_front());
                m_cv = (h.rd != 0); m_crd = h.rd; m_cval = h.val; m_ctag = 4'(h.tag);
            end else m_cv = 0;
            if (acc) begin
                q.push_back('{tag: m_tail, rd: ird, done: 0, val: 0});
                m_tail = (m_tail + 1) % N;
            end
        end
    endtask

    // One clock: drive, check the combinational tag, clock, check outputs.
    task automatic step(input bit rst, input bit rdy, input bit iv, input logic [4:0] ird,
                        input bit cv, input logic [3:0] ct, input logic [31:0] cval, input bit fl);
        rst_in = rst; rdy_in = rdy; issue_valid = iv; issue_rd = ird;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
`ifdef ROB_FLUSH_EN
        flush = fl;
`endif
        #2;
        if (!rst) chk("issue_tag", 32'(issue_tag), 32'(m_tail));
        model(rst, rdy, iv, ird, cv, ct, cval, fl);
        @(posedge clk_in); #1;
        chk("full", 32'(full), 32'(q.size() == N));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("commit_valid", 32'(commit_valid), 32'(m_cv));
        chk("commit_rd", 32'(commit_rd), 32'(m_crd));
        chk("commit_value", commit_value, m_cval);
        chk("commit_tag", 32'(commit_tag), 32'(m_ctag));
    endtask

    task automatic reset_dut();   step(1, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle();        step(0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic issue(input logic [4:0] rd); step(0, 1, 1, rd, 0, 0, 0, 0); endtask
    task automatic cdb(input logic [3:0] t, input logic [31:0] v); step(0, 1, 0, 0, 1, t, v, 0); endtask

    initial begin
        bit          r_rst, r_rdy, r_iv, r_cv, r_fl;
        logic [3:0]  r_ct;
        rst_in = 1; rdy_in = 1; issue_valid = 0; issue_rd = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
`ifdef ROB_FLUSH_EN
        flush = 0;
`endif
        @(posedge clk_in); #1;

        // Reset state.
        reset_dut();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_tag", 32'(issue_tag), 32'd0);

        // Single instruction, 3-edge issue-to-commit.
        issue(5);
        cdb(0, 32'hDEADBEEF);
        chk("t1_no_early_commit", 32'(commit_valid), 32'd0);
        idle();
        chk("t1_cv", 32'(commit_valid), 32'd1);
        chk("t1_rd", 32'(commit_rd), 32'd5);
        chk("t1_val", commit_value, 32'hDEADBEEF);
        idle();
        chk("t1_pulse", 32'(commit_valid), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Out-of-order completion, in-order retirement.
        reset_dut();
        issue(1); issue(2); issue(3);
        cdb(2, 32'h22); cdb(1, 32'h11);
        chk("t2_wait_head", 32'(commit_valid), 32'd0);
        cdb(0, 32'h00);
        idle(); chk("t2_rd1", 32'(commit_rd), 32'd1);
        idle(); chk("t2_rd2", 32'(commit_rd), 32'd2);
        idle(); chk("t2_rd3", 32'(commit_rd), 32'd3);

        // Fill, overflow attempt, wrap.
        reset_dut();
        for (int i = 0; i < N; i++) issue(5'(i + 1));
        chk("t3_full", 32'(full), 32'd1);
        issue(31);
        chk("t3_tail_held", 32'(issue_tag), 32'd0);
        cdb(0, 32'h1234);
        idle();
        chk("t3_full_drop", 32'(full), 32'd0);
        issue(9);
        chk("t3_full_again", 32'(full), 32'd1);

        // x0 destination retires silently.
        reset_dut();
        issue(0); cdb(0, 32'h55); idle();
        chk("t4_silent", 32'(commit_valid), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);

        // Concurrent issue/CDB/retire, then a 3-cycle rdy_in freeze.
        reset_dut();
        issue(4); issue(5); issue(6);
        cdb(0, 32'hA0);
        step(0, 1, 1, 7, 1, 1, 32'hA1, 0);
        chk("t5_commit_rd", 32'(commit_rd), 32'd4);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8, 1, 2, 32'hBAD, 0);
        chk("t5_frozen_tag", 32'(issue_tag), 32'd4);
        idle();
        chk("t5_resume_rd", 32'(commit_rd), 32'd5);

`ifdef ROB_FLUSH_EN
        // Flush wins over a head that is ready to retire.
        reset_dut();
        issue(1); issue(2); issue(3); issue(4);
        cdb(0, 32'hF0);
        step(0, 1, 1, 9, 0, 0, 0, 1);
        chk("t6_no_commit", 32'(commit_valid), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_tag0", 32'(issue_tag), 32'd0);
`endif

        // Randomized traffic.
        reset_dut();
        for (int c = 0; c < 1500; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_rdy = ($urandom_range(0, 9) != 0);
            r_iv  = ($urandom_range(0, 9) < 6);
            r_cv  = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 4) != 0)
                r_ct = 4'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                r_ct = 4'($urandom_range(0, N - 1));
`ifdef ROB_FLUSH_EN
            r_fl = ($urandom_range(0, 59) == 0);
`else
            r_fl = 0;
`endif
            step(r_rst, r_rdy, r_iv, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)),
                 r_cv, r_ct, $urandom, r_fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
